// File: rtl/comp_pkg.sv
// Shared definitions for the compression-side framer.
package comp_pkg;

  localparam int unsigned GROUP_BEATS_DEF = 8;
  localparam logic [31:0] MAGIC_DEF       = 32'h434D_5052;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned KEEP_W = 32;

  // Control/header beat field positions
  localparam int unsigned BMAP_LSB     = 0;
  localparam int unsigned CNT_LSB      = 8;
  localparam int unsigned LASTG_BIT    = 12;
  localparam int unsigned HDR_FLAG_BIT = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    COLLECT,
    CTRL,
    EMIT
  } comp_state_t;

  // A beat is elided only when every byte is present and every byte is zero
  function automatic logic is_zero_beat(input logic [DATA_W-1:0] d,
                                        input logic [KEEP_W-1:0] k);
    return (k == '1) && (d == '0);
  endfunction

endpackage

// File: rtl/comp_group_buf.sv
// Group buffer: beat storage, zero bitmap and next-literal scan for EMIT.
module comp_group_buf
  import comp_pkg::*;
#(
  parameter int unsigned GROUP_BEATS = GROUP_BEATS_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEEP_W-1:0] wr_keep,
  input  logic              wr_zero,
  input  logic [3:0]        fill,
  input  logic [3:0]        rd_from,
  output logic [7:0]        bitmap,
  output logic [2:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [KEEP_W-1:0] rd_keep,
  output logic              has_more,
  output logic              has_after
);

  logic [DATA_W-1:0] mem_data [GROUP_BEATS];
  logic [KEEP_W-1:0] mem_keep [GROUP_BEATS];
  logic [7:0]        lit;

  // Beat storage; contents are don't-care until written, so no reset
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_data[wr_idx] <= wr_data;
      mem_keep[wr_idx] <= wr_keep;
    end
  end

  // Zero bitmap, cleared at the start of every group
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bitmap <= '0;
    end else if (clr) begin
      bitmap <= '0;
    end else if (wr_en) begin
      bitmap[wr_idx] <= wr_zero;
    end
  end

  // Find the lowest literal at or above rd_from, and whether another follows it
  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      lit[i] = (fill > 4'(i)) && (rd_from <= 4'(i)) && !bitmap[i];
    end
    rd_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (lit[i-1]) rd_idx = 3'(i - 1);
    end
    has_more  = |lit;
    has_after = |(lit & (lit - 8'd1));
  end

  assign rd_data = mem_data[rd_idx];
  assign rd_keep = mem_keep[rd_idx];

endmodule

// File: rtl/comp_top.sv
// Compression framer: header per packet, then pass-through or zero-elided groups.
module comp_top
  import comp_pkg::*;
#(
  parameter int unsigned GROUP_BEATS = GROUP_BEATS_DEF,
  parameter logic [31:0] MAGIC       = MAGIC_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              comp_en,
  input  logic [DATA_W-1:0] tdata_dma,
  input  logic [KEEP_W-1:0] tkeep_dma,
  input  logic              tvalid_dma,
  input  logic              tlast_dma,
  output logic              tready_dma,
  output logic [DATA_W-1:0] tdata_fifo,
  output logic [KEEP_W-1:0] tkeep_fifo,
  output logic              tvalid_fifo,
  output logic              tlast_fifo,
  input  logic              tready_fifo
);

  comp_state_t state, state_nxt;

  logic        mode;
  logic [3:0]  cnt;
  logic        last_grp;
  logic        ctl_loaded;
  logic [3:0]  rd_ptr;

  logic              can_load;
  logic              ld_en;
  logic [DATA_W-1:0] ld_data;
  logic [KEEP_W-1:0] ld_keep;
  logic              ld_last;
  logic              wr_en;
  logic              grp_clr;
  logic              ctl_ld;
  logic              rd_adv;
  logic              mode_ld;

  logic [7:0]        bitmap;
  logic [2:0]        rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [KEEP_W-1:0] rd_keep;
  logic              has_more;
  logic              has_after;

  assign can_load = !tvalid_fifo || tready_fifo;

  comp_group_buf #(
    .GROUP_BEATS(GROUP_BEATS)
  ) u_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clr       (grp_clr),
    .wr_en     (wr_en),
    .wr_idx    (cnt[2:0]),
    .wr_data   (tdata_dma),
    .wr_keep   (tkeep_dma),
    .wr_zero   (is_zero_beat(tdata_dma, tkeep_dma)),
    .fill      (cnt),
    .rd_from   (rd_ptr),
    .bitmap    (bitmap),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_keep   (rd_keep),
    .has_more  (has_more),
    .has_after (has_after)
  );

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, input ready and output-register load selection
  always_comb begin
    state_nxt  = state;
    tready_dma = 1'b0;
    ld_en      = 1'b0;
    ld_data    = '0;
    ld_keep    = '1;
    ld_last    = 1'b0;
    wr_en      = 1'b0;
    grp_clr    = 1'b0;
    ctl_ld     = 1'b0;
    rd_adv     = 1'b0;
    mode_ld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tvalid_dma && can_load) begin
          ld_en                 = 1'b1;
          ld_data[31:0]         = MAGIC;
          ld_data[HDR_FLAG_BIT] = comp_en;
          mode_ld               = 1'b1;
          state_nxt             = HDR;
        end
      end
      HDR: begin
        if (tvalid_fifo && tready_fifo) begin
          if (mode) begin
            state_nxt = COLLECT;
            grp_clr   = 1'b1;
          end else begin
            state_nxt = PASS;
          end
        end
      end
      PASS: begin
        tready_dma = can_load;
        if (tvalid_dma && can_load) begin
          ld_en   = 1'b1;
          ld_data = tdata_dma;
          ld_keep = tkeep_dma;
          ld_last = tlast_dma;
          if (tlast_dma) state_nxt = IDLE;
        end
      end
      COLLECT: begin
        tready_dma = 1'b1;
        if (tvalid_dma) begin
          wr_en = 1'b1;
          if (tlast_dma || ((cnt + 4'd1) == 4'(GROUP_BEATS))) state_nxt = CTRL;
        end
      end
      CTRL: begin
        // Load once, then hold here until the control beat itself is accepted
        if (!ctl_loaded) begin
          if (can_load) begin
            ld_en                     = 1'b1;
            ld_data[BMAP_LSB +: 8]    = bitmap;
            ld_data[CNT_LSB +: 4]     = cnt;
            ld_data[LASTG_BIT]        = last_grp;
            ld_last                   = last_grp && !has_more;
            ctl_ld                    = 1'b1;
          end
        end else if (tvalid_fifo && tready_fifo) begin
          if (has_more) begin
            state_nxt = EMIT;
          end else if (last_grp) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = COLLECT;
            grp_clr   = 1'b1;
          end
        end
      end
      EMIT: begin
        if (can_load) begin
          if (has_more) begin
            ld_en   = 1'b1;
            ld_data = rd_data;
            ld_keep = rd_keep;
            ld_last = last_grp && !has_after;
            rd_adv  = 1'b1;
          end else if (last_grp) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = COLLECT;
            grp_clr   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Group bookkeeping: mode, fill count, last-group flag, read pointer
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mode       <= 1'b0;
      cnt        <= '0;
      last_grp   <= 1'b0;
      ctl_loaded <= 1'b0;
      rd_ptr     <= '0;
    end else begin
      if (mode_ld) mode <= comp_en;
      if (grp_clr) begin
        cnt      <= '0;
        last_grp <= 1'b0;
        rd_ptr   <= '0;
      end else begin
        if (wr_en) begin
          cnt      <= cnt + 4'd1;
          last_grp <= tlast_dma;
        end
        if (rd_adv) rd_ptr <= {1'b0, rd_idx} + 4'd1;
      end
      ctl_loaded <= (state_nxt == CTRL) && (ctl_loaded || ctl_ld);
    end
  end

  // Output register: load on a free slot, otherwise drain on accept
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tvalid_fifo <= 1'b0;
      tlast_fifo  <= 1'b0;
      tdata_fifo  <= '0;
      tkeep_fifo  <= '0;
    end else if (ld_en) begin
      tvalid_fifo <= 1'b1;
      tlast_fifo  <= ld_last;
      tdata_fifo  <= ld_data;
      tkeep_fifo  <= ld_keep;
    end else if (tready_fifo) begin
      tvalid_fifo <= 1'b0;
    end
  end

endmodule

// File: doc/comp_top.md
# comp_top

Compression-side framer between the DMA read stream and the outbound FIFO; the transmit counterpart of the decompression front end. Every packet gets a one-beat header whose mode flag tells the far-end decompressor whether to decompress or pass through. In compressed mode, input beats are gathered into groups of up to GROUP_BEATS. Each group is emitted as one control beat carrying a zero-beat bitmap, followed only by its non-zero beats. In pass-through mode, beats are forwarded through one registered stage.

## Interface
- GROUP_BEATS, 8: max input beats per group; legal range 1..8.
- MAGIC, 32'h434D_5052: header signature in header data[31:0].
- aclk  in  1  sole clock; all logic on its rising edge.
- aresetn  in  1  synchronous, active-low reset.
- comp_en  in  1  mode select; sampled once per packet, at header launch.
- tdata_dma  in  256  input data from DMA.
- tkeep_dma  in  32  input byte enables.
- tvalid_dma  in  1  input valid.
- tlast_dma  in  1  last beat of packet.
- tready_dma  out  1  input ready.
- tdata_fifo  out  256  output data to FIFO.
- tkeep_fifo  out  32  output byte enables.
- tvalid_fifo  out  1  output valid.
- tlast_fifo  out  1  output last.
- tready_fifo  in  1  output ready.

## Operation
- Zero beat: tkeep_dma == 32'hFFFF_FFFF and tdata_dma == 0. A partial-keep beat is always a literal beat.
- Header beat fields:
  - data[31:0] = MAGIC.
  - data[32] = sampled comp_en.
  - all other bits 0.
  - tkeep all ones, tlast 0.
- Control beat fields:
  - data[7:0] = zero bitmap; bit i set means group beat i was a zero beat.
  - data[11:8] = group beat count, 1..8.
  - data[12] = last group of packet.
  - all other bits 0; tkeep all ones.
  - tlast = 1 only if this is the last group and the group has no literal beats.
- Literal beats: group beats whose bitmap bit is clear, in arrival order, with original tdata/tkeep. tlast is set on the final literal of the last group.
- FSM states:
  - IDLE: tready_dma=0. When tvalid_dma=1 and the output register is empty or being accepted: latch comp_en into mode, load header -> HDR. The first data beat is not consumed in this state.
  - HDR: on header accept -> PASS if mode=0, else COLLECT.
  - PASS: tready_dma = !tvalid_fifo || tready_fifo. Each accepted input beat is loaded into the output register unchanged. Accepting the input tlast beat -> IDLE.
  - COLLECT: tready_dma=1. Accepted beats are written at index cnt, bitmap[cnt] is set for zero beats, cnt is incremented. The group closes when cnt reaches GROUP_BEATS or a tlast beat is accepted -> CTRL; the last flag is latched when closed by tlast.
  - CTRL: tready_dma=0. Load the control beat; on its accept:
    - -> EMIT if any literal exists;
    - else -> IDLE if the last flag is set;
    - else -> COLLECT, with cnt and bitmap cleared.
  - EMIT: tready_dma=0. Step through the buffer, skipping zero entries, one literal per output handshake. After the final literal is accepted -> IDLE if last, else COLLECT with cnt and bitmap cleared.
- A packet arriving as a lone tlast beat produces: header, control (count 1), then the literal or, for a zero beat, no literal. The end of the packet is marked on the control beat if there is no literal, otherwise on the literal.
- comp_en changes mid-packet are ignored until the next IDLE->HDR launch.

## Timing
- Reset (aresetn=0 at clock edge): state IDLE; tvalid_fifo, tlast_fifo, tready_dma = 0; tdata_fifo, tkeep_fifo = 0; cnt, bitmap and mode cleared. Buffer contents are not reset.
- Reset mid-packet: all buffered and in-flight data is dropped, with no partial control or literal output. After release, the bench restarts on a packet boundary.
- All outputs are registered. Output data holds stable while tvalid_fifo=1 and tready_fifo=0; tvalid never drops without a handshake.
- Pass-through latency: 1 cycle from input handshake to tvalid_fifo. Full throughput with tready_fifo held high.
- Header costs 1 output beat per packet; no input is consumed during IDLE, HDR, CTRL or EMIT.
- A compressed group of N beats with L literals occupies at least N + 1 + L cycles.
- The group buffer is never full while tready_dma=1, because a group closes on its GROUP_BEATS-th write.

## Structure
- Package comp_pkg holds: the MAGIC default, GROUP_BEATS default, state encoding (IDLE, HDR, PASS, COLLECT, CTRL, EMIT), and control-beat field bit positions (BMAP_LSB=0, CNT_LSB=8, LASTG_BIT=12, HDR_FLAG_BIT=32).
- Sub-module comp_group_buf holds:
  - GROUP_BEATS x (256+32) register array with write port;
  - bitmap register;
  - next-non-zero read-index scan, with a has_more output for EMIT.

## Test plan
- comp_en=0; 3-beat packet A,B,C (C tkeep=32'h0000_FFFF, tlast) -> output header (data[32]=0), then A, B, C; tlast only on C; C keeps 32'h0000_FFFF.
- comp_en=1; 8 beats with beats 1,2,5 zero and beat 7 tlast -> header (data[32]=1); control with bitmap 8'h26, count 8, last=1; literals 0,3,4,6,7; tlast on beat 7.
- comp_en=1; 10 beats, all non-zero -> header; control (bitmap 0, count 8, last 0) + 8 literals; control (count 2, last 1) + 2 literals; tlast on final beat.
- comp_en=1; 4 all-zero beats, last with tlast -> header; one control beat with bitmap 8'h0F, count 4, last 1, tlast=1; no literals.
- Random tready_fifo stalls on the previous two cases -> identical output sequence; data held stable during stalls.
- Assert aresetn=0 during EMIT -> next cycle tvalid_fifo=0, tready_dma=0; a following packet is framed cleanly starting with a header.
